// File: rtl/host_arb2.sv
// Two-requester round-robin arbiter sharing one host-bus slave.
// Each requester owns a one-deep command slot. At most one read is outstanding, and a timeout guard releases the bus.
module host_arb2 #(
   parameter int              AW         = 32,
   parameter int              DW         = 32,
   parameter int              RD_TIMEOUT = 64,
   parameter logic [DW-1:0]   TO_DATA    = 'hDEAD_DEAD
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_cmd_vld,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_data_w,
   input  logic          m0_rw,
   output logic          m0_busy,
   output logic [DW-1:0] m0_data_r,
   output logic          m0_rd_vld,
   input  logic          m1_cmd_vld,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_data_w,
   input  logic          m1_rw,
   output logic          m1_busy,
   output logic [DW-1:0] m1_data_r,
   output logic          m1_rd_vld,
   output logic          s_cmd_vld,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_data_w,
   output logic          s_rw,
   input  logic [DW-1:0] s_data_r,
   input  logic          s_rd_vld,
   input  logic          err_clr,
   output logic          drop_err,
   output logic          to_err
);

   localparam int            CW      = $clog2(RD_TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          issue, to_hit;
   logic [1:0]    free, ret;
   logic [DW-1:0] ret_data;

   logic [1:0]    cmd_vld, accept, drop, busy_q, rd_vld_q;
   logic [AW-1:0] cmd_addr [2];
   logic [DW-1:0] cmd_data [2];
   logic [1:0]    cmd_rw;
   logic [AW-1:0] slot_addr [2];
   logic [DW-1:0] slot_data [2];
   logic [1:0]    slot_rw;
   logic [DW-1:0] data_r_q [2];

   assign cmd_vld     = {m1_cmd_vld, m0_cmd_vld};
   assign cmd_addr[0] = m0_addr;
   assign cmd_addr[1] = m1_addr;
   assign cmd_data[0] = m0_data_w;
   assign cmd_data[1] = m1_data_w;
   assign cmd_rw      = {m1_rw, m0_rw};
   // A strobe against an occupied slot is dropped even if the slot frees on this edge.
   assign accept      = cmd_vld & ~busy_q;
   assign drop        = cmd_vld & busy_q;

   assign m0_busy   = busy_q[0];
   assign m1_busy   = busy_q[1];
   assign m0_rd_vld = rd_vld_q[0];
   assign m1_rd_vld = rd_vld_q[1];
   assign m0_data_r = data_r_q[0];
   assign m1_data_r = data_r_q[1];

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d  = state_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      issue    = 1'b0;
      free     = 2'b00;
      ret      = 2'b00;
      ret_data = s_data_r;
      to_hit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|busy_q) begin
               grant_d = (&busy_q) ? ~grant_q : busy_q[1];
               issue   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = '0;
            if (slot_rw[grant_q]) begin
               free[grant_q] = 1'b1;
               state_d       = IDLE;
            end else begin
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            cnt_d = cnt_q + CW'(1);
            if (s_rd_vld) begin
               ret[grant_q]  = 1'b1;
               free[grant_q] = 1'b1;
               state_d       = IDLE;
            end else if (cnt_q == TO_LAST) begin
               ret[grant_q]  = 1'b1;
               free[grant_q] = 1'b1;
               ret_data      = TO_DATA;
               to_hit        = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= 1'b1;
         cnt_q       <= '0;
         busy_q      <= 2'b00;
         s_cmd_vld   <= 1'b0;
         s_addr      <= '0;
         s_data_w    <= '0;
         s_rw        <= 1'b0;
         rd_vld_q    <= 2'b00;
         data_r_q[0] <= '0;
         data_r_q[1] <= '0;
         drop_err    <= 1'b0;
         to_err      <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         busy_q    <= (busy_q & ~free) | accept;
         s_cmd_vld <= issue;
         if (issue) begin
            s_addr   <= slot_addr[grant_d];
            s_data_w <= slot_data[grant_d];
            s_rw     <= slot_rw[grant_d];
         end
         rd_vld_q <= ret;
         for (int i = 0; i < 2; i++) begin
            if (ret[i]) data_r_q[i] <= ret_data;
         end
         drop_err <= (|drop) | (drop_err & ~err_clr);
         to_err   <= to_hit | (to_err & ~err_clr);
      end
   end

   // NOTE: slot payload is not reset; it is only read while busy marks it valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (accept[i]) begin
            slot_addr[i] <= cmd_addr[i];
            slot_data[i] <= cmd_data[i];
            slot_rw[i]   <= cmd_rw[i];
         end
      end
   end

endmodule

// File: tb/tb_host_arb2.sv
// Self-checking bench for host_arb2: scoreboard of expected downstream commands and read returns,
// table-driven single transactions, plus hand-written arbitration, drop, timeout and reset sequences.
module tb_host_arb2;
   localparam int          TMO     = 8;
   localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

   typedef struct {int cyc; logic [31:0] addr; logic [31:0] data; logic rw;} cmd_exp_t;
   typedef struct {int cyc; int id; logic [31:0] data;} rd_exp_t;
   typedef struct {bit id; bit rw; logic [31:0] addr; logic [31:0] data; int dly; logic [31:0] rdata;} vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic m0_cmd_vld, m0_rw, m0_busy, m0_rd_vld;
   logic m1_cmd_vld, m1_rw, m1_busy, m1_rd_vld;
   logic [31:0] m0_addr, m0_data_w, m0_data_r, m1_addr, m1_data_w, m1_data_r;
   logic s_cmd_vld, s_rw, s_rd_vld, err_clr, drop_err, to_err;
   logic [31:0] s_addr, s_data_w, s_data_r;

   cmd_exp_t cmd_q[$];
   rd_exp_t  rd_q[$];
   vec_t     vecs[6];
   int       cyc, n_checks, n_fail, n0;

   host_arb2 #(.AW(32), .DW(32), .RD_TIMEOUT(TMO), .TO_DATA(TO_DATA)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cmd_vld(m0_cmd_vld), .m0_addr(m0_addr), .m0_data_w(m0_data_w), .m0_rw(m0_rw),
      .m0_busy(m0_busy), .m0_data_r(m0_data_r), .m0_rd_vld(m0_rd_vld),
      .m1_cmd_vld(m1_cmd_vld), .m1_addr(m1_addr), .m1_data_w(m1_data_w), .m1_rw(m1_rw),
      .m1_busy(m1_busy), .m1_data_r(m1_data_r), .m1_rd_vld(m1_rd_vld),
      .s_cmd_vld(s_cmd_vld), .s_addr(s_addr), .s_data_w(s_data_w), .s_rw(s_rw),
      .s_data_r(s_data_r), .s_rd_vld(s_rd_vld),
      .err_clr(err_clr), .drop_err(drop_err), .to_err(to_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic busy_of(input bit id);
      return id ? m1_busy : m0_busy;
   endfunction

   task automatic push_cmd(input int c, input logic [31:0] a, input logic [31:0] d, input logic rw);
      cmd_exp_t e;
      e.cyc = c; e.addr = a; e.data = d; e.rw = rw;
      cmd_q.push_back(e);
   endtask

   task automatic push_rd(input int c, input int id, input logic [31:0] d);
      rd_exp_t e;
      e.cyc = c; e.id = id; e.data = d;
      rd_q.push_back(e);
   endtask

   task automatic drive(input bit id, input bit rw, input logic [31:0] a, input logic [31:0] d);
      if (id == 1'b0) begin
         m0_cmd_vld = 1'b1; m0_rw = rw; m0_addr = a; m0_data_w = d;
      end else begin
         m1_cmd_vld = 1'b1; m1_rw = rw; m1_addr = a; m1_data_w = d;
      end
   endtask

   // Advance one cycle, clear one-cycle strobes, and compare DUT events against the scoreboard.
   task automatic tick();
      cmd_exp_t    ce;
      rd_exp_t     re;
      logic [1:0]  rv;
      logic [31:0] rdat [2];
      @(posedge clk);
      #1;
      cyc++;
      m0_cmd_vld = 1'b0; m1_cmd_vld = 1'b0; s_rd_vld = 1'b0; err_clr = 1'b0;
      s_data_r = $urandom();
      if (s_cmd_vld) begin
         if (cmd_q.size() == 0) check("cmd_unexpected", 64'(s_cmd_vld), 64'd0);
         else begin
            ce = cmd_q.pop_front();
            check("cmd_cycle", 64'(cyc), 64'(ce.cyc));
            check("cmd_fields", {s_addr, s_data_w}, {ce.addr, ce.data});
            check("cmd_rw", 64'(s_rw), 64'(ce.rw));
         end
      end
      rv = {m1_rd_vld, m0_rd_vld};
      rdat[0] = m0_data_r;
      rdat[1] = m1_data_r;
      for (int k = 0; k < 2; k++) begin
         if (rv[k]) begin
            if (rd_q.size() == 0) check("rd_unexpected", 64'(rv[k]), 64'd0);
            else begin
               re = rd_q.pop_front();
               check("rd_owner", 64'(k), 64'(re.id));
               check("rd_cycle", 64'(cyc), 64'(re.cyc));
               check("rd_data", 64'(rdat[k]), 64'(re.data));
            end
         end
      end
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0;
      rst_n = 1'b0; err_clr = 1'b0; s_rd_vld = 1'b0; s_data_r = '0;
      m0_cmd_vld = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_data_w = '0;
      m1_cmd_vld = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_data_w = '0;

      vecs[0] = '{id: 1'b0, rw: 1'b1, addr: 32'h10,       data: 32'hA5A5_A5A5, dly: 0, rdata: 32'h0};
      vecs[1] = '{id: 1'b1, rw: 1'b0, addr: 32'h20,       data: 32'h0,         dly: 3, rdata: 32'h1234_5678};
      vecs[2] = '{id: 1'b1, rw: 1'b1, addr: 32'h24,       data: 32'h0BAD_F00D, dly: 0, rdata: 32'h0};
      vecs[3] = '{id: 1'b0, rw: 1'b0, addr: 32'h14,       data: 32'h0,         dly: 1, rdata: 32'hFFFF_0000};
      vecs[4] = '{id: 1'b0, rw: 1'b0, addr: 32'h18,       data: 32'h0,         dly: 5, rdata: 32'h00C0_FFEE};
      vecs[5] = '{id: 1'b1, rw: 1'b1, addr: 32'hFFFF_FFFC, data: 32'hFFFF_FFFF, dly: 0, rdata: 32'h0};

      repeat (2) tick();
      check("rst_ctrl", 64'({s_cmd_vld, s_rw, m0_busy, m1_busy, m0_rd_vld, m1_rd_vld, drop_err, to_err}), 64'd0);
      check("rst_s_fields", {s_addr, s_data_w}, 64'd0);
      check("rst_data_r", {m0_data_r, m1_data_r}, 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Single transactions, one at a time.
      for (int v = 0; v < 6; v++) begin
         n0 = cyc;
         drive(vecs[v].id, vecs[v].rw, vecs[v].addr, vecs[v].data);
         push_cmd(n0 + 2, vecs[v].addr, vecs[v].data, vecs[v].rw);
         tick();
         check("busy_set", 64'(busy_of(vecs[v].id)), 64'd1);
         tick();
         if (vecs[v].rw) begin
            tick();
            check("busy_clr_wr", 64'(busy_of(vecs[v].id)), 64'd0);
            tick();
            check("s_hold", {s_addr, s_data_w}, {vecs[v].addr, vecs[v].data});
         end else begin
            repeat (vecs[v].dly) tick();
            s_rd_vld = 1'b1;
            s_data_r = vecs[v].rdata;
            push_rd(cyc + 1, int'(vecs[v].id), vecs[v].rdata);
            tick();
            check("busy_clr_rd", 64'(busy_of(vecs[v].id)), 64'd0);
            repeat (2) tick();
            check("data_r_hold", 64'(vecs[v].id ? m1_data_r : m0_data_r), 64'(vecs[v].rdata));
         end
         tick();
      end

      // Simultaneous writes: m0 wins each tie, m1 follows two cycles later.
      for (int r = 0; r < 4; r++) begin
         n0 = cyc;
         drive(1'b0, 1'b1, 32'h100 + 32'(r), 32'hA000_0000 + 32'(r));
         drive(1'b1, 1'b1, 32'h200 + 32'(r), 32'hB000_0000 + 32'(r));
         push_cmd(n0 + 2, 32'h100 + 32'(r), 32'hA000_0000 + 32'(r), 1'b1);
         push_cmd(n0 + 4, 32'h200 + 32'(r), 32'hB000_0000 + 32'(r), 1'b1);
         repeat (6) tick();
      end

      // After a solo m0 grant, the next tie goes to m1.
      n0 = cyc;
      drive(1'b0, 1'b1, 32'h300, 32'h3);
      push_cmd(n0 + 2, 32'h300, 32'h3, 1'b1);
      repeat (4) tick();
      n0 = cyc;
      drive(1'b0, 1'b1, 32'h310, 32'h31);
      drive(1'b1, 1'b1, 32'h320, 32'h32);
      push_cmd(n0 + 2, 32'h320, 32'h32, 1'b1);
      push_cmd(n0 + 4, 32'h310, 32'h31, 1'b1);
      repeat (6) tick();

      // Drop while busy, sticky until err_clr.
      n0 = cyc;
      drive(1'b0, 1'b1, 32'h50, 32'h5050);
      push_cmd(n0 + 2, 32'h50, 32'h5050, 1'b1);
      tick();
      drive(1'b0, 1'b1, 32'h60, 32'h6060);
      tick();
      check("drop_set", 64'(drop_err), 64'd1);
      repeat (2) tick();
      check("drop_sticky", 64'(drop_err), 64'd1);
      err_clr = 1'b1;
      tick();
      check("drop_clr", 64'(drop_err), 64'd0);
      tick();

      // Drop on the edge the slot frees, with err_clr in the same cycle: set wins.
      n0 = cyc;
      drive(1'b0, 1'b1, 32'h70, 32'h7070);
      push_cmd(n0 + 2, 32'h70, 32'h7070, 1'b1);
      repeat (2) tick();
      check("busy_at_issue", 64'(m0_busy), 64'd1);
      drive(1'b0, 1'b1, 32'h80, 32'h8080);
      err_clr = 1'b1;
      tick();
      check("drop_set_wins", 64'(drop_err), 64'd1);
      check("drop_not_captured", 64'(m0_busy), 64'd0);
      repeat (3) tick();
      err_clr = 1'b1;
      tick();
      check("drop_clr2", 64'(drop_err), 64'd0);

      // s_rd_vld during ISSUE is ignored; the real response arrives later.
      n0 = cyc;
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      push_cmd(n0 + 2, 32'h40, 32'h0, 1'b0);
      repeat (2) tick();
      s_rd_vld = 1'b1;
      s_data_r = 32'h0000_0BAD;
      repeat (2) tick();
      s_rd_vld = 1'b1;
      s_data_r = 32'hCAFE_0001;
      push_rd(cyc + 1, 1, 32'hCAFE_0001);
      repeat (3) tick();

      // Read timeout.
      n0 = cyc;
      drive(1'b0, 1'b0, 32'h30, 32'h0);
      push_cmd(n0 + 2, 32'h30, 32'h0, 1'b0);
      push_rd(n0 + 3 + TMO, 0, TO_DATA);
      while (cyc < n0 + 2 + TMO) tick();
      check("to_err_early", 64'(to_err), 64'd0);
      tick();
      check("to_err_set", 64'(to_err), 64'd1);
      s_rd_vld = 1'b1;
      s_data_r = 32'h5555_5555;
      repeat (2) tick();
      check("to_err_sticky", 64'(to_err), 64'd1);
      check("to_busy_clr", 64'(m0_busy), 64'd0);
      err_clr = 1'b1;
      tick();
      check("to_err_clr", 64'(to_err), 64'd0);
      tick();

      // Reset in the middle of a read.
      n0 = cyc;
      drive(1'b0, 1'b0, 32'h90, 32'h0);
      push_cmd(n0 + 2, 32'h90, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'h91, 32'h91);
      repeat (3) tick();
      check("pre_rst_drop", 64'(drop_err), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ctrl", 64'({s_cmd_vld, s_rw, m0_busy, m1_busy, m0_rd_vld, m1_rd_vld, drop_err, to_err}), 64'd0);
      check("mid_rst_s_fields", {s_addr, s_data_w}, 64'd0);
      check("mid_rst_data_r", {m0_data_r, m1_data_r}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      s_rd_vld = 1'b1;
      s_data_r = 32'h7777_7777;
      repeat (3) tick();
      check("post_rst_busy", 64'({m0_busy, m1_busy}), 64'd0);

      // Grant pointer restored by reset: m0 wins the first tie again.
      n0 = cyc;
      drive(1'b0, 1'b1, 32'hA0, 32'hA0A0);
      drive(1'b1, 1'b1, 32'hB0, 32'hB0B0);
      push_cmd(n0 + 2, 32'hA0, 32'hA0A0, 1'b1);
      push_cmd(n0 + 4, 32'hB0, 32'hB0B0, 1'b1);
      repeat (8) tick();

      check("cmd_sb_drained", 64'(cmd_q.size()), 64'd0);
      check("rd_sb_drained", 64'(rd_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
